// File: rtl/microwave_controller.sv
// Microwave oven controller: BCD MM:SS keypad entry, countdown cook timer,
// pause/resume on stop or door, and a timed cook-complete indication.
module microwave_controller #(
    parameter int DONE_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    input  logic       sec_tick,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic       mag_on,
    output logic       timer_done,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SET    = 3'd1,
        COOK   = 3'd2,
        PAUSED = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int CW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;

    state_t        state_q, state_d;
    logic [3:0]    mt_q, mo_q, st_q, so_q;
    logic [3:0]    mt_d, mo_d, st_d, so_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          time_zero, time_one, start_ok, key_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mt_q    <= '0;
            mo_q    <= '0;
            st_q    <= '0;
            so_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mt_q    <= mt_d;
            mo_q    <= mo_d;
            st_q    <= st_d;
            so_q    <= so_d;
            cnt_q   <= cnt_d;
        end
    end

    assign time_zero = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
    assign time_one  = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd1);
    // Door/stop conditions are already excluded by the higher-priority branch below.
    assign start_ok  = !startn && ((state_q == SET) || (state_q == PAUSED)) && !time_zero;
    assign key_ok    = key_valid && (key_digit <= 4'd9) && ((state_q == IDLE) || (state_q == SET));

    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mo_d    = mo_q;
        st_d    = st_q;
        so_d    = so_q;
        cnt_d   = cnt_q;

        if (!clearn) begin
            state_d = IDLE;
            mt_d    = '0;
            mo_d    = '0;
            st_d    = '0;
            so_d    = '0;
            cnt_d   = '0;
        end else if (!stopn || !door_closed) begin
            if (state_q == COOK) begin
                state_d = PAUSED;
            end else if ((state_q == DONE) && !door_closed) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else if (start_ok) begin
            state_d = COOK;
        end else if (key_ok) begin
            mt_d    = mo_q;
            mo_d    = st_q;
            st_d    = so_q;
            so_d    = key_digit;
            state_d = SET;
        end else if (sec_tick) begin
            if (state_q == COOK) begin
                if (so_q != 4'd0) begin
                    so_d = so_q - 4'd1;
                end else begin
                    so_d = 4'd9;
                    if (st_q != 4'd0) begin
                        st_d = st_q - 4'd1;
                    end else begin
                        st_d = 4'd5;
                        if (mo_q != 4'd0) begin
                            mo_d = mo_q - 4'd1;
                        end else begin
                            mo_d = 4'd9;
                            mt_d = mt_q - 4'd1;
                        end
                    end
                end
                if (time_one) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end else if (state_q == DONE) begin
                if (cnt_q == CW'(DONE_TICKS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    assign state      = state_q;
    assign mag_on     = (state_q == COOK) && door_closed;
    assign timer_done = (state_q == DONE);
    assign min_tens   = mt_q;
    assign min_ones   = mo_q;
    assign sec_tens   = st_q;
    assign sec_ones   = so_q;

endmodule

// File: tb/tb_microwave_controller.sv
// Scoreboard bench for microwave_controller: expectations are queued as each
// stimulus cycle is driven and compared after the following rising edge.
module tb_microwave_controller;

    localparam logic [2:0] S_IDLE = 3'd0, S_SET = 3'd1, S_COOK = 3'd2,
                           S_PAUSED = 3'd3, S_DONE = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       startn = 1'b1, stopn = 1'b1, clearn = 1'b1, door_closed = 1'b1;
    logic       sec_tick = 1'b0, key_valid = 1'b0;
    logic [3:0] key_digit = '0;
    logic       mag_on, timer_done;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] state;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [15:0] tm;
        logic        mag;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cur_m, cur_s;

    microwave_controller #(.DONE_TICKS(3)) dut (
        .clk(clk), .rst(rst), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .sec_tick(sec_tick), .key_valid(key_valid),
        .key_digit(key_digit), .mag_on(mag_on), .timer_done(timer_done),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] bcd_time(input int m, input int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic step(input string tag, input logic s_n, input logic st_n, input logic cl_n,
                        input logic tk, input logic kv, input logic [3:0] kd,
                        input logic [2:0] est, input logic [15:0] etm,
                        input logic emag, input logic edone);
        exp_t e;
        startn = s_n; stopn = st_n; clearn = cl_n; sec_tick = tk; key_valid = kv; key_digit = kd;
        sb.push_back('{tag, est, etm, emag, edone});
        @(posedge clk);
        #1;
        startn = 1'b1; stopn = 1'b1; clearn = 1'b1; sec_tick = 1'b0; key_valid = 1'b0;
        e = sb.pop_front();
        check({e.tag, "_state"}, state, e.st);
        check({e.tag, "_time"}, {min_tens, min_ones, sec_tens, sec_ones}, e.tm);
        check({e.tag, "_mag"}, mag_on, e.mag);
        check({e.tag, "_done"}, timer_done, e.done);
    endtask

    task automatic key(input string tag, input logic [3:0] d, input logic [15:0] etm);
        step(tag, 1, 1, 1, 0, 1, d, S_SET, etm, 0, 0);
    endtask

    task automatic start_cook(input string tag, input int m, input int s);
        cur_m = m;
        cur_s = s;
        step(tag, 0, 1, 1, 0, 0, 0, S_COOK, bcd_time(m, s), 1, 0);
    endtask

    task automatic clear(input string tag);
        step(tag, 1, 1, 0, 0, 0, 0, S_IDLE, 16'h0000, 0, 0);
    endtask

    // Reference countdown works on whole minutes/seconds, then converts to BCD.
    task automatic cook_tick(input string tag);
        logic fin;
        cur_s--;
        if (cur_s < 0) begin
            cur_s = 59;
            cur_m--;
        end
        fin = (cur_m == 0) && (cur_s == 0);
        step(tag, 1, 1, 1, 1, 0, 0, fin ? S_DONE : S_COOK, bcd_time(cur_m, cur_s), !fin, fin);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_state", state, S_IDLE);
        check("rst_time", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        check("rst_mag", mag_on, 0);
        check("rst_done", timer_done, 0);
        @(negedge clk);
        rst = 1'b0;

        key("k1", 4'd1, 16'h0001);
        key("k3", 4'd3, 16'h0013);
        key("k0", 4'd0, 16'h0130);
        start_cook("start130", 1, 30);
        cook_tick("t129");
        for (int i = 0; i < 29; i++) cook_tick("t_to100");
        cook_tick("t059");
        for (int i = 0; i < 58; i++) cook_tick("t_to001");
        cook_tick("t000");
        step("done_hold", 1, 1, 1, 0, 0, 0, S_DONE, 16'h0000, 0, 1);
        step("done_key", 1, 1, 1, 0, 1, 4'd5, S_DONE, 16'h0000, 0, 1);
        step("done_start", 0, 1, 1, 0, 0, 0, S_DONE, 16'h0000, 0, 1);
        step("done_t1", 1, 1, 1, 1, 0, 0, S_DONE, 16'h0000, 0, 1);
        step("done_t2", 1, 1, 1, 1, 0, 0, S_DONE, 16'h0000, 0, 1);
        step("done_t3", 1, 1, 1, 1, 0, 0, S_IDLE, 16'h0000, 0, 0);

        key("k4", 4'd4, 16'h0004);
        key("k5", 4'd5, 16'h0045);
        start_cook("start045", 0, 45);
        door_closed = 1'b0;
        #1;
        check("door_mag_comb", mag_on, 0);
        step("door_tick", 1, 1, 1, 1, 0, 0, S_PAUSED, 16'h0045, 0, 0);
        step("paused_tick", 1, 1, 1, 1, 0, 0, S_PAUSED, 16'h0045, 0, 0);
        door_closed = 1'b1;
        start_cook("resume045", 0, 45);
        cook_tick("t044");
        step("stop", 1, 0, 1, 0, 0, 0, S_PAUSED, 16'h0044, 0, 0);
        clear("clr1");

        key("k9", 4'd9, 16'h0009);
        key("k0b", 4'd0, 16'h0090);
        step("bad_key", 1, 1, 1, 0, 1, 4'd12, S_SET, 16'h0090, 0, 0);
        start_cook("start090", 0, 90);
        for (int i = 0; i < 31; i++) cook_tick("t_from090");
        check("t90_final", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0059);
        clear("clr2");

        key("ka1", 4'd1, 16'h0001);
        key("ka2", 4'd2, 16'h0012);
        key("ka3", 4'd3, 16'h0123);
        key("ka4", 4'd4, 16'h1234);
        key("ka5", 4'd5, 16'h2345);
        step("clr_start", 0, 1, 0, 0, 0, 0, S_IDLE, 16'h0000, 0, 0);
        step("start_idle", 0, 1, 1, 0, 0, 0, S_IDLE, 16'h0000, 0, 0);
        key("kz", 4'd0, 16'h0000);
        step("start_set_zero", 0, 1, 1, 0, 0, 0, S_SET, 16'h0000, 0, 0);

        key("km1", 4'd9, 16'h0009);
        key("km2", 4'd9, 16'h0099);
        key("km3", 4'd5, 16'h0995);
        key("km4", 4'd9, 16'h9959);
        start_cook("start9959", 99, 59);
        cook_tick("t9958");
        clear("clr3");

        key("kr2", 4'd2, 16'h0002);
        key("kr0", 4'd0, 16'h0020);
        start_cook("start020", 0, 20);
        #2 rst = 1'b1;
        #1;
        check("arst_mag", mag_on, 0);
        check("arst_state", state, S_IDLE);
        check("arst_time", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        check("arst_done", timer_done, 0);
        rst = 1'b0;
        step("post_rst", 1, 1, 1, 1, 0, 0, S_IDLE, 16'h0000, 0, 0);
        key("k7", 4'd7, 16'h0007);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/microwave_controller.md
MICROWAVE_CONTROLLER -- requirements
Module: microwave_controller

Interface
REQ-001 Parameter DONE_TICKS, default 3: number of sec_tick pulses that timer_done stays asserted before the controller returns to IDLE.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 startn  input  1  start button, active-low level, sampled each clk.
REQ-005 stopn  input  1  stop/pause button, active-low level.
REQ-006 clearn  input  1  clear button, active-low level.
REQ-007 door_closed  input  1  1 = door closed.
REQ-008 sec_tick  input  1  one-clk-wide pulse, once per second.
REQ-009 key_valid  input  1  one-clk strobe qualifying key_digit.
REQ-010 key_digit  input  4  keypad digit, BCD.
REQ-011 mag_on  output  1  magnetron enable.
REQ-012 timer_done  output  1  cook-complete indication.
REQ-013 min_tens, min_ones, sec_tens, sec_ones  output  4 each  remaining time MM:SS, BCD.
REQ-014 state  output  3  FSM state: IDLE=0, SET=1, COOK=2, PAUSED=3, DONE=4.

Function
REQ-015 The controller SHALL implement five states (IDLE, SET, COOK, PAUSED, DONE); encodings 5-7 SHALL never occur.
REQ-016 Each clk, events SHALL be resolved in this priority order: clearn=0 > (stopn=0 or door_closed=0) > startn=0 > key_valid > sec_tick.
REQ-017 clearn=0 in any state SHALL force IDLE next cycle, with all four digits at 0 and timer_done=0.
REQ-018 In IDLE or SET, key_valid with key_digit<=9 SHALL shift the digits left (min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit) and enter SET; the old min_tens is discarded.
REQ-019 key_digit>9, or key_valid in COOK, PAUSED or DONE, SHALL be ignored.
REQ-020 Entered sec_tens values 6-9 SHALL be accepted unchanged (e.g. 00:90 means 90 s).
REQ-021 startn=0 in SET or PAUSED, with door_closed=1, stopn=1 and a nonzero time, SHALL enter COOK next cycle.
REQ-022 startn=0 with time 00:00, or in IDLE, COOK or DONE, SHALL have no effect.
REQ-023 In COOK, stopn=0 or door_closed=0 SHALL enter PAUSED next cycle with the time retained; a sec_tick in that same cycle SHALL NOT decrement.
REQ-024 In COOK, each sec_tick SHALL decrement MM:SS by 1 s with BCD borrow:
  - sec_ones 0 -> 9 with borrow;
  - sec_tens 0 -> 5 with borrow;
  - min_ones 0 -> 9 with borrow;
  - min_tens decrements by 1.
  - Example: 10:00 -> 09:59.
REQ-025 A sec_tick in COOK at 00:01 SHALL produce 00:00 and enter DONE on the same edge.
REQ-026 In DONE, timer_done SHALL be 1 and an internal counter SHALL count sec_tick pulses.
REQ-027 On the DONE_TICKS-th sec_tick in DONE, the controller SHALL return to IDLE with timer_done=0.
REQ-028 Opening the door or asserting clearn in DONE SHALL return to IDLE immediately (next cycle).
REQ-029 mag_on SHALL equal (state==COOK) AND door_closed, combinationally, so that opening the door drops mag_on in the same cycle.
REQ-030 Maximum time SHALL be 99:59; no digit output SHALL ever leave the range 0-9.

Reset
REQ-031 rst=1 SHALL immediately, without waiting for clk, force:
  - state=IDLE;
  - all digits 0;
  - mag_on=0, timer_done=0;
  - DONE tick counter 0.
REQ-032 rst asserted mid-COOK SHALL drop mag_on asynchronously; after release, the controller SHALL wait in IDLE for key entry.

Verification
REQ-033 The bench SHALL cover: rst; keys 1,3,0 -> 01:30, state=SET; startn=0 with door closed -> state=COOK, mag_on=1; one sec_tick -> 01:29.
REQ-034 The bench SHALL cover: COOK at 01:00, sec_tick -> 00:59; at 00:01, sec_tick -> 00:00, state=DONE, timer_done=1, mag_on=0; 3 sec_ticks -> IDLE, timer_done=0.
REQ-035 The bench SHALL cover: COOK at 00:45; door_closed=0 together with sec_tick -> mag_on=0 that cycle, state=PAUSED, time stays 00:45; door_closed=1 plus startn=0 -> COOK.
REQ-036 The bench SHALL cover: keys 9,0 -> 00:90; COOK with 31 sec_ticks -> 00:59.
REQ-037 The bench SHALL cover:
  - keys 1,2,3,4,5 -> 23:45;
  - clearn=0 together with startn=0 -> IDLE, 00:00;
  - startn=0 at 00:00 -> remains IDLE.
REQ-038 The bench SHALL cover: rst pulse mid-COOK between clock edges -> mag_on=0 and state=IDLE before the next rising edge.
